// File: rtl/sel_arb_pkg.sv
// Shared encodings for the 2:1 selector arbiter: FSM state values and SEL polarity.
package sel_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GNT_A = 2'd1;
   localparam logic [1:0] ST_GNT_B = 2'd2;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StGntA = ST_GNT_A,
      StGntB = ST_GNT_B
   } state_e;

   function automatic state_e sel_to_state(logic sel);
      return (sel == SEL_B) ? StGntB : StGntA;
   endfunction

endpackage

// File: rtl/sel_2_1_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the downstream consumer.
interface sel_2_1_arbiter_if #(
   parameter int unsigned W = 8
);

   logic         A_VALID;
   logic [W-1:0] A_DATA;
   logic         A_READY;
   logic         B_VALID;
   logic [W-1:0] B_DATA;
   logic         B_READY;
   logic         SEL;
   logic         OUT_VALID;
   logic [W-1:0] OUT_DATA;
   logic         OUT_READY;

   // master drives requests and downstream ready; slave is the arbiter
   modport master (
      output A_VALID, A_DATA, B_VALID, B_DATA, OUT_READY,
      input  A_READY, B_READY, SEL, OUT_VALID, OUT_DATA
   );

   modport slave (
      input  A_VALID, A_DATA, B_VALID, B_DATA, OUT_READY,
      output A_READY, B_READY, SEL, OUT_VALID, OUT_DATA
   );

endinterface

// File: rtl/sel_2_1_data.sv
// W-bit combinational 2:1 data selector steered by the arbiter's SEL.
module sel_2_1_data
   import sel_arb_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         sel_i,
   input  logic [W-1:0] a_data_i,
   input  logic [W-1:0] b_data_i,
   output logic [W-1:0] data_o
);

   always_comb begin
      data_o = (sel_i == SEL_B) ? b_data_i : a_data_i;
   end

endmodule

// File: rtl/sel_2_1_arbiter.sv
// Round-robin burst arbiter for two VALID/READY requesters sharing one registered output.
module sel_2_1_arbiter
   import sel_arb_pkg::*;
#(
   parameter int unsigned W         = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input logic              CLK,
   input logic              RST_N,
   sel_2_1_arbiter_if.slave bus
);

   localparam int unsigned      CNT_W   = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CntMax  = CNT_W'(MAX_BURST);

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sel_q, sel_d;
   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     out_data_q, out_data_d;

   logic             granted;
   logic             gnt_sel;
   logic             cur_valid;
   logic             oth_valid;
   logic             slot_free;
   logic             accept;
   logic             release_gnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [W-1:0]     mux_data;

   sel_2_1_data #(
      .W (W)
   ) u_data (
      .sel_i    (sel_q),
      .a_data_i (bus.A_DATA),
      .b_data_i (bus.B_DATA),
      .data_o   (mux_data)
   );

   always_comb begin
      granted     = (state_q == StGntA) || (state_q == StGntB);
      gnt_sel     = (state_q == StGntB) ? SEL_B : SEL_A;
      cur_valid   = (state_q == StGntB) ? bus.B_VALID : bus.A_VALID;
      oth_valid   = (state_q == StGntB) ? bus.A_VALID : bus.B_VALID;
      // output slot can take a beat if empty or being drained this cycle
      slot_free   = !out_valid_q || bus.OUT_READY;
      accept      = granted && cur_valid && slot_free;
      cnt_inc     = cnt_q + CNT_W'(1);
      release_gnt = granted && ((accept && (cnt_inc == CntMax)) || (!cur_valid && slot_free));
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      sel_d       = sel_q;
      out_valid_d = out_valid_q && !bus.OUT_READY;
      out_data_d  = out_data_q;

      if (accept) begin
         out_data_d  = mux_data;
         out_valid_d = 1'b1;
         cnt_d       = cnt_inc;
      end

      unique case (state_q)
         StIdle: begin
            // on a tie the requester that was not served last wins
            if (bus.A_VALID && (!bus.B_VALID || (last_q == SEL_B))) begin
               state_d = StGntA;
               sel_d   = SEL_A;
            end else if (bus.B_VALID) begin
               state_d = StGntB;
               sel_d   = SEL_B;
            end
         end
         StGntA, StGntB: begin
            if (release_gnt) begin
               last_d = gnt_sel;
               cnt_d  = '0;
               if (oth_valid) begin
                  state_d = sel_to_state(~gnt_sel);
                  sel_d   = ~gnt_sel;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= StIdle;
         last_q      <= SEL_B;
         cnt_q       <= '0;
         sel_q       <= SEL_A;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.A_READY   = (state_q == StGntA) && slot_free;
   assign bus.B_READY   = (state_q == StGntB) && slot_free;
   assign bus.SEL       = sel_q;
   assign bus.OUT_VALID = out_valid_q;
   assign bus.OUT_DATA  = out_data_q;

endmodule

// File: tb/tb_sel_2_1_arbiter.sv
// Scoreboard bench: directed requester traffic, expected output beats queued and checked by monitors.
module tb_sel_2_1_arbiter;

   localparam int unsigned W = 8;

   typedef struct {
      logic [7:0] data;
      int         gap;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   exp_t       exp0_q[$];
   exp_t       exp1_q[$];
   logic [7:0] a0_q[$];
   logic [7:0] b0_q[$];
   logic [7:0] a1_q[$];
   logic [7:0] b1_q[$];

   sel_2_1_arbiter_if #(.W(W)) if0 ();
   sel_2_1_arbiter_if #(.W(W)) if1 ();

   sel_2_1_arbiter #(
      .W         (W),
      .MAX_BURST (4)
   ) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (if0.slave)
   );

   sel_2_1_arbiter #(
      .W         (W),
      .MAX_BURST (1)
   ) dut1 (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (if1.slave)
   );

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic void push0(logic [7:0] d, int gap);
      exp_t e;
      e.data = d;
      e.gap  = gap;
      exp0_q.push_back(e);
   endfunction

   function automatic void push1(logic [7:0] d, int gap);
      exp_t e;
      e.data = d;
      e.gap  = gap;
      exp1_q.push_back(e);
   endfunction

   // monitor: every downstream transfer pops one expected beat and checks spacing
   initial begin : mon
      exp_t e;
      int   mcyc;
      int   last0;
      int   last1;
      mcyc  = 0;
      last0 = 0;
      last1 = 0;
      forever begin
         @(negedge clk);
         mcyc++;
         if (rst_n) begin
            if (if0.OUT_VALID && if0.OUT_READY) begin
               check("main_beat_expected", 32'(exp0_q.size() != 0), 32'd1);
               if (exp0_q.size() != 0) begin
                  e = exp0_q.pop_front();
                  check("main_data", 32'(if0.OUT_DATA), 32'(e.data));
                  if (e.gap >= 0) check("main_gap", 32'(mcyc - last0), 32'(e.gap));
               end
               last0 = mcyc;
            end
            if (if1.OUT_VALID && if1.OUT_READY) begin
               check("mb1_beat_expected", 32'(exp1_q.size() != 0), 32'd1);
               if (exp1_q.size() != 0) begin
                  e = exp1_q.pop_front();
                  check("mb1_data", 32'(if1.OUT_DATA), 32'(e.data));
                  if (e.gap >= 0) check("mb1_gap", 32'(mcyc - last1), 32'(e.gap));
               end
               last1 = mcyc;
            end
         end
      end
   end

   // n cycles of requester traffic from the source queues; B held off until cycle b_start;
   // OUT_READY low for st_len cycles from st_start, during which the held beat must be st_data
   task automatic run(input int n, input int b_start, input int st_start, input int st_len,
                      input logic [7:0] st_data);
      logic af0, bf0, af1, bf1;
      for (int k = 0; k < n; k++) begin
         if0.A_VALID   = (a0_q.size() != 0);
         if0.A_DATA    = (a0_q.size() != 0) ? a0_q[0] : 8'h00;
         if0.B_VALID   = (k >= b_start) && (b0_q.size() != 0);
         if0.B_DATA    = (b0_q.size() != 0) ? b0_q[0] : 8'h00;
         if0.OUT_READY = !((k >= st_start) && (k < st_start + st_len));
         if1.A_VALID   = (a1_q.size() != 0);
         if1.A_DATA    = (a1_q.size() != 0) ? a1_q[0] : 8'h00;
         if1.B_VALID   = (b1_q.size() != 0);
         if1.B_DATA    = (b1_q.size() != 0) ? b1_q[0] : 8'h00;
         if1.OUT_READY = 1'b1;
         @(negedge clk);
         af0 = if0.A_VALID && if0.A_READY;
         bf0 = if0.B_VALID && if0.B_READY;
         af1 = if1.A_VALID && if1.A_READY;
         bf1 = if1.B_VALID && if1.B_READY;
         if (!if0.OUT_READY) begin
            check("stall_b_ready", 32'(if0.B_READY), 32'd0);
            check("stall_a_ready", 32'(if0.A_READY), 32'd0);
            check("stall_out_valid", 32'(if0.OUT_VALID), 32'd1);
            check("stall_out_data", 32'(if0.OUT_DATA), 32'(st_data));
         end
         @(posedge clk);
         #1;
         if (af0) void'(a0_q.pop_front());
         if (bf0) void'(b0_q.pop_front());
         if (af1) void'(a1_q.pop_front());
         if (bf1) void'(b1_q.pop_front());
      end
      if0.A_VALID = 1'b0;
      if0.B_VALID = 1'b0;
      if1.A_VALID = 1'b0;
      if1.B_VALID = 1'b0;
   endtask

   initial begin
      if0.A_VALID = 1'b0; if0.A_DATA = '0; if0.B_VALID = 1'b0; if0.B_DATA = '0;
      if0.OUT_READY = 1'b1;
      if1.A_VALID = 1'b0; if1.A_DATA = '0; if1.B_VALID = 1'b0; if1.B_DATA = '0;
      if1.OUT_READY = 1'b1;
      rst_n = 1'b0;
      #1;
      check("rst_sel", 32'(if0.SEL), 32'd0);
      check("rst_out_valid", 32'(if0.OUT_VALID), 32'd0);
      check("rst_out_data", 32'(if0.OUT_DATA), 32'd0);
      check("rst_a_ready", 32'(if0.A_READY), 32'd0);
      check("rst_b_ready", 32'(if0.B_READY), 32'd0);
      check("rst_mb1_out_valid", 32'(if1.OUT_VALID), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // tie from reset: 4 A, 4 B, 4 A back-to-back
      for (int i = 0; i < 8; i++) a0_q.push_back(8'hA0 + 8'(i));
      for (int i = 0; i < 4; i++) b0_q.push_back(8'hB0 + 8'(i));
      for (int i = 0; i < 4; i++) push0(8'hA0 + 8'(i), (i == 0) ? -1 : 1);
      for (int i = 0; i < 4; i++) push0(8'hB0 + 8'(i), 1);
      for (int i = 4; i < 8; i++) push0(8'hA0 + 8'(i), 1);
      run(16, 0, 99, 0, 8'h00);

      // short A burst alone, then release to idle
      a0_q.push_back(8'h11); a0_q.push_back(8'h22);
      push0(8'h11, -1); push0(8'h22, 1);
      run(6, 0, 99, 0, 8'h00);
      check("idle_a_ready", 32'(if0.A_READY), 32'd0);
      check("idle_b_ready", 32'(if0.B_READY), 32'd0);

      // short A burst with B waiting: direct handoff, one beatless release cycle
      a0_q.push_back(8'h44); a0_q.push_back(8'h55); b0_q.push_back(8'h66);
      push0(8'h44, -1); push0(8'h55, 1); push0(8'h66, 2);
      run(8, 1, 99, 0, 8'h00);
      check("sel_held_idle", 32'(if0.SEL), 32'd1);

      // backpressure during a B grant
      b0_q.push_back(8'hC1); b0_q.push_back(8'hC2); b0_q.push_back(8'hC3);
      push0(8'hC1, -1); push0(8'hC2, 1); push0(8'hC3, 1);
      run(10, 0, 2, 3, 8'hC1);

      // lone B, 10 beats: re-grant through idle after each 4-beat burst
      for (int i = 0; i < 10; i++) b0_q.push_back(8'hD0 + 8'(i));
      for (int i = 0; i < 10; i++) push0(8'hD0 + 8'(i), (i == 0) ? -1 : ((i % 4 == 0) ? 2 : 1));
      run(16, 0, 99, 0, 8'h00);

      // MAX_BURST=1 instance, both saturated: alternate every beat
      for (int i = 0; i < 4; i++) begin
         a1_q.push_back(8'hA0 + 8'(i));
         b1_q.push_back(8'hB0 + 8'(i));
         push1(8'hA0 + 8'(i), (i == 0) ? -1 : 1);
         push1(8'hB0 + 8'(i), 1);
      end
      run(12, 0, 99, 0, 8'h00);

      // async reset mid-burst with a beat held in the output register
      for (int i = 0; i < 4; i++) b0_q.push_back(8'hE0 + 8'(i));
      run(2, 0, 99, 0, 8'h00);
      check("pre_rst_out_valid", 32'(if0.OUT_VALID), 32'd1);
      check("pre_rst_out_data", 32'(if0.OUT_DATA), 32'hE0);
      check("pre_rst_sel", 32'(if0.SEL), 32'd1);
      #2 rst_n = 1'b0;
      b0_q.delete();
      #1;
      check("async_rst_sel", 32'(if0.SEL), 32'd0);
      check("async_rst_out_valid", 32'(if0.OUT_VALID), 32'd0);
      check("async_rst_out_data", 32'(if0.OUT_DATA), 32'd0);
      check("async_rst_a_ready", 32'(if0.A_READY), 32'd0);
      check("async_rst_b_ready", 32'(if0.B_READY), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run(5, 0, 99, 0, 8'h00);
      check("post_rst_a_ready", 32'(if0.A_READY), 32'd0);
      check("post_rst_b_ready", 32'(if0.B_READY), 32'd0);

      check("main_leftover", 32'(exp0_q.size()), 32'd0);
      check("mb1_leftover", 32'(exp1_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
